cmd_frame_ctrl: RTL and testbench



---
 rtl/cmd_frame_ctrl_if.sv | 44 ++++
 rtl/cmd_frame_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_cmd_frame_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : cmd_frame_ctrl_if
// Desc    : Bus bundle between cmd_frame_ctrl (master) and its RX/RF/ALU/FIFO
//           environment (slave).
// Rev     : 1.0
// ============================================================================
interface cmd_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RES_BYTES  = 2
);
    logic [DATA_WIDTH-1:0]           RX_P_Data;
    logic                            RX_D_VLD;
    logic [ADDR_WIDTH-1:0]           Address;
    logic                            Wr_En;
    logic                            Rd_En;
    logic [DATA_WIDTH-1:0]           WrData;
    logic [DATA_WIDTH-1:0]           RdData;
    logic                            RdData_Valid;
    logic [3:0]                      ALU_FUN;
    logic                            Enable;
    logic                            Gate_EN;
    logic [RES_BYTES*DATA_WIDTH-1:0] ALU_OUT;
    logic                            OUT_Valid;
    logic                            Fifo_Full;
    logic                            WR_INC;
    logic [DATA_WIDTH-1:0]           Fifo_Wr_Data;
    logic                            clk_div_en;
    logic                            Frame_Err;

    modport master (
        input  RX_P_Data, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, Fifo_Full,
        output Address, Wr_En, Rd_En, WrData, ALU_FUN, Enable, Gate_EN,
               WR_INC, Fifo_Wr_Data, clk_div_en, Frame_Err
    );

    modport slave (
        output RX_P_Data, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, Fifo_Full,
        input  Address, Wr_En, Rd_En, WrData, ALU_FUN, Enable, Gate_EN,
               WR_INC, Fifo_Wr_Data, clk_div_en, Frame_Err
    );
endinterface
`default_nettype wire

// File: rtl/cmd_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cmd_frame_ctrl
// Desc    : Decodes RX command frames into RF writes/reads and ALU runs, and
//           pushes results into the TX FIFO. Define CMD_TIMEOUT_EN to abort
//           stalled partial frames after TIMEOUT_CYC idle cycles.
// Rev     : 1.0
// ============================================================================
module cmd_frame_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int RES_BYTES   = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    cmd_frame_ctrl_if.master bus
);

    localparam int RES_W = RES_BYTES * DATA_WIDTH;
    localparam int CNT_W = $clog2(RES_BYTES + 1);

    localparam logic [DATA_WIDTH-1:0] c_cmd_wr  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] c_cmd_rd  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] c_cmd_alu = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] c_cmd_nop = DATA_WIDTH'(8'hDD);

    if (ADDR_WIDTH > DATA_WIDTH || DATA_WIDTH < 8 || RES_BYTES < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("cmd_frame_ctrl: unsupported parameter set");
    end

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WR_ADDR  = 4'd1,
        S_WR_DATA  = 4'd2,
        S_RD_ADDR  = 4'd3,
        S_RD_WAIT  = 4'd4,
        S_OP_A     = 4'd5,
        S_OP_B     = 4'd6,
        S_FUN      = 4'd7,
        S_ALU_WAIT = 4'd8,
        S_PUSH     = 4'd9
    } state_t;

    state_t                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   address_q,   address_d;
    logic [DATA_WIDTH-1:0]   wr_data_q,   wr_data_d;
    logic                    wr_en_q,     wr_en_d;
    logic                    rd_en_q,     rd_en_d;
    logic [3:0]              alu_fun_q,   alu_fun_d;
    logic                    alu_en_q,    alu_en_d;
    logic [RES_W-1:0]        result_q,    result_d;
    logic [CNT_W-1:0]        words_q,     words_d;
    logic                    wr_inc_q,    wr_inc_d;
    logic [DATA_WIDTH-1:0]   fifo_data_q, fifo_data_d;
    logic                    frame_err_q, frame_err_d;
    logic                    clk_div_en_q;

`ifdef CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]        tmo_q,       tmo_d;
    logic                    w_frame_open;
`endif

    logic [DATA_WIDTH-1:0]   w_byte;
    logic                    w_vld;

    assign w_byte = bus.RX_P_Data;
    assign w_vld  = bus.RX_D_VLD;

    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        alu_fun_d   = alu_fun_q;
        alu_en_d    = alu_en_q;
        result_d    = result_q;
        words_d     = words_q;
        wr_inc_d    = 1'b0;
        fifo_data_d = fifo_data_q;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_vld) begin
                    if (w_byte == c_cmd_wr)       state_d = S_WR_ADDR;
                    else if (w_byte == c_cmd_rd)  state_d = S_RD_ADDR;
                    else if (w_byte == c_cmd_alu) state_d = S_OP_A;
                    else if (w_byte == c_cmd_nop) state_d = S_FUN;
                    else                          frame_err_d = 1'b1;
                end
            end
            S_WR_ADDR: begin
                if (w_vld) begin
                    address_d = w_byte[ADDR_WIDTH-1:0];
                    state_d   = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (w_vld) begin
                    wr_data_d = w_byte;
                    wr_en_d   = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (w_vld) begin
                    address_d = w_byte[ADDR_WIDTH-1:0];
                    rd_en_d   = 1'b1;
                    state_d   = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                frame_err_d = w_vld;
                if (bus.RdData_Valid) begin
                    result_d = RES_W'(bus.RdData);
                    words_d  = CNT_W'(1);
                    state_d  = S_PUSH;
                end
            end
            S_OP_A: begin
                if (w_vld) begin
                    address_d = '0;
                    wr_data_d = w_byte;
                    wr_en_d   = 1'b1;
                    state_d   = S_OP_B;
                end
            end
            S_OP_B: begin
                if (w_vld) begin
                    address_d = ADDR_WIDTH'(1);
                    wr_data_d = w_byte;
                    wr_en_d   = 1'b1;
                    state_d   = S_FUN;
                end
            end
            S_FUN: begin
                if (w_vld) begin
                    alu_fun_d = w_byte[3:0];
                    alu_en_d  = 1'b1;
                    state_d   = S_ALU_WAIT;
                end
            end
            S_ALU_WAIT: begin
                frame_err_d = w_vld;
                if (bus.OUT_Valid) begin
                    result_d = bus.ALU_OUT;
                    words_d  = CNT_W'(RES_BYTES);
                    alu_en_d = 1'b0;
                    state_d  = S_PUSH;
                end
            end
            S_PUSH: begin
                frame_err_d = w_vld;
                // Result drains LS word first by shifting the holding register down.
                if (!bus.Fifo_Full) begin
                    wr_inc_d    = 1'b1;
                    fifo_data_d = result_q[DATA_WIDTH-1:0];
                    result_d    = result_q >> DATA_WIDTH;
                    words_d     = words_q - CNT_W'(1);
                    if (words_q == CNT_W'(1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef CMD_TIMEOUT_EN
        // Counts only while a partial frame is waiting on its next RX byte.
        w_frame_open = (state_q == S_WR_ADDR) || (state_q == S_WR_DATA) ||
                       (state_q == S_RD_ADDR) || (state_q == S_OP_A)    ||
                       (state_q == S_OP_B)    || (state_q == S_FUN);
        tmo_d = '0;
        if (w_frame_open && !w_vld) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                state_d     = S_IDLE;
                frame_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            address_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            alu_fun_q    <= '0;
            alu_en_q     <= 1'b0;
            result_q     <= '0;
            words_q      <= '0;
            wr_inc_q     <= 1'b0;
            fifo_data_q  <= '0;
            frame_err_q  <= 1'b0;
            clk_div_en_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            alu_fun_q    <= alu_fun_d;
            alu_en_q     <= alu_en_d;
            result_q     <= result_d;
            words_q      <= words_d;
            wr_inc_q     <= wr_inc_d;
            fifo_data_q  <= fifo_data_d;
            frame_err_q  <= frame_err_d;
            clk_div_en_q <= 1'b1;
`ifdef CMD_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign bus.Address      = address_q;
    assign bus.Wr_En        = wr_en_q;
    assign bus.Rd_En        = rd_en_q;
    assign bus.WrData       = wr_data_q;
    assign bus.ALU_FUN      = alu_fun_q;
    assign bus.Enable       = alu_en_q;
    assign bus.Gate_EN      = alu_en_q;
    assign bus.WR_INC       = wr_inc_q;
    assign bus.Fifo_Wr_Data = fifo_data_q;
    assign bus.clk_div_en   = clk_div_en_q;
    assign bus.Frame_Err    = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cmd_frame_ctrl
// Desc    : Self-checking bench for cmd_frame_ctrl with an RF/ALU/FIFO model.
// Rev     : 1.0
// ============================================================================
module tb_cmd_frame_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int RB  = 2;
    localparam int TMO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmd_frame_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RES_BYTES(RB)) bus ();

    cmd_frame_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RES_BYTES  (RB),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus.master)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0]    env_rf [16];
    logic [DW-1:0]    ref_rf [16];
    logic [AW+DW-1:0] exp_wr[$],   obs_wr[$];
    logic [DW-1:0]    exp_fifo[$], obs_fifo[$];
    int exp_rd = 0, rd_seen = 0, exp_err = 0, err_seen = 0;
    int full_viol = 0, gate_viol = 0;
    int alu_lat = 2;
    int bp_mode = 0;
    logic ff_at_edge = 1'b0;

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return {8'h00, a & b};
            4'd4:    return {8'h00, a | b};
            4'd5:    return {8'h00, a ^ b};
            default: return {a, b};
        endcase
    endfunction

    // Register file and ALU behaviour as seen from the DUT's strobes.
    initial begin
        int rd_cnt;
        int alu_cnt;
        bit alu_active;
        logic [AW-1:0] rd_a;
        rd_cnt = 0; alu_cnt = 0; alu_active = 1'b0; rd_a = '0;
        bus.RdData = '0; bus.RdData_Valid = 1'b0; bus.ALU_OUT = '0; bus.OUT_Valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.RdData_Valid = 1'b0;
            bus.OUT_Valid    = 1'b0;
            if (!rst_n) begin
                rd_cnt = 0; alu_cnt = 0; alu_active = 1'b0;
            end else begin
                if (bus.Wr_En) env_rf[bus.Address] = bus.WrData;
                if (bus.Rd_En) begin
                    rd_cnt = $urandom_range(1, 4);
                    rd_a   = bus.Address;
                end else if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        bus.RdData       = env_rf[rd_a];
                        bus.RdData_Valid = 1'b1;
                    end
                end
                if (!bus.Enable) begin
                    alu_active = 1'b0;
                end else if (!alu_active) begin
                    alu_active = 1'b1;
                    alu_cnt    = alu_lat;
                end else if (alu_cnt > 0) begin
                    alu_cnt--;
                    if (alu_cnt == 0) begin
                        bus.ALU_OUT   = alu_f(env_rf[0], env_rf[1], bus.ALU_FUN);
                        bus.OUT_Valid = 1'b1;
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        ff_at_edge = bus.Fifo_Full;
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus.Wr_En)  obs_wr.push_back({bus.Address, bus.WrData});
            if (bus.WR_INC) begin
                obs_fifo.push_back(bus.Fifo_Wr_Data);
                if (ff_at_edge) full_viol++;
            end
            if (bus.Rd_En)     rd_seen++;
            if (bus.Frame_Err) err_seen++;
            if (bus.Enable !== bus.Gate_EN) gate_viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        case (bp_mode)
            1:       bus.Fifo_Full = ($urandom_range(0, 2) == 0);
            2:       bus.Fifo_Full = 1'b1;
            default: bus.Fifo_Full = 1'b0;
        endcase
    endtask

    task automatic send_ng(input logic [DW-1:0] b);
        bus.RX_P_Data = b;
        bus.RX_D_VLD  = 1'b1;
        tick();
        bus.RX_D_VLD  = 1'b0;
        bus.RX_P_Data = '0;
    endtask

    task automatic send(input logic [DW-1:0] b);
        send_ng(b);
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic wait_fifo();
        int k;
        k = 0;
        while (obs_fifo.size() < exp_fifo.size() && k < 300) begin
            tick();
            k++;
        end
    endtask

    task automatic drain_check(input string tag);
        chk({tag, ":wr_cnt"},   32'(obs_wr.size()),   32'(exp_wr.size()));
        chk({tag, ":fifo_cnt"}, 32'(obs_fifo.size()), 32'(exp_fifo.size()));
        while (exp_wr.size() > 0 && obs_wr.size() > 0)
            chk({tag, ":wr"}, 32'(obs_wr.pop_front()), 32'(exp_wr.pop_front()));
        while (exp_fifo.size() > 0 && obs_fifo.size() > 0)
            chk({tag, ":fifo"}, 32'(obs_fifo.pop_front()), 32'(exp_fifo.pop_front()));
        exp_wr.delete(); obs_wr.delete(); exp_fifo.delete(); obs_fifo.delete();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_wr.push_back({a, d});
        ref_rf[a] = d;
        send(8'hAA);
        send({4'($urandom_range(0, 15)), a});
        send(d);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        exp_fifo.push_back(ref_rf[a]);
        exp_rd++;
        send(8'hBB);
        send({4'($urandom_range(0, 15)), a});
        wait_fifo();
    endtask

    task automatic push_result(input logic [15:0] r);
        exp_fifo.push_back(r[7:0]);
        exp_fifo.push_back(r[15:8]);
    endtask

    task automatic do_alu(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] f);
        exp_wr.push_back({4'd0, a});
        exp_wr.push_back({4'd1, b});
        ref_rf[0] = a;
        ref_rf[1] = b;
        push_result(alu_f(a, b, f));
        send(8'hCC); send(a); send(b); send({4'($urandom_range(0, 15)), f});
        wait_fifo();
    endtask

    task automatic do_nop(input logic [3:0] f);
        push_result(alu_f(ref_rf[0], ref_rf[1], f));
        send(8'hDD); send({4'h0, f});
        wait_fifo();
    endtask

    initial begin
        logic [DW-1:0] b;
        int kind;
        int k;
        for (int i = 0; i < 16; i++) begin
            env_rf[i] = '0;
            ref_rf[i] = '0;
        end
        bus.RX_P_Data = '0;
        bus.RX_D_VLD  = 1'b0;
        bus.Fifo_Full = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({bus.Wr_En, bus.Rd_En, bus.WR_INC, bus.Enable, bus.Gate_EN,
                                  bus.Frame_Err, bus.Address, bus.WrData, bus.ALU_FUN,
                                  bus.Fifo_Wr_Data}), 32'h0);
        chk("reset_clk_div_en", 32'(bus.clk_div_en), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("clk_div_en_after_release", 32'(bus.clk_div_en), 32'h1);

        // RF write
        do_write(4'd5, 8'h3C);
        repeat (3) tick();
        drain_check("rf_write");

        // RF read under back-pressure
        do_write(4'd7, 8'h5A);
        repeat (3) tick();
        drain_check("rf_write7");
        bp_mode = 2;
        bus.Fifo_Full = 1'b1;
        exp_fifo.push_back(8'h5A);
        exp_rd++;
        send_ng(8'hBB);
        send_ng(8'h07);
        repeat (10) tick();
        chk("bp_no_push", 32'(obs_fifo.size()), 32'h0);
        chk("bp_rd_en_once", 32'(rd_seen), 32'(exp_rd));
        bp_mode = 0;
        wait_fifo();
        drain_check("rf_read_bp");

        // ALU with operands: 0x10 * 0x03
        do_alu(8'h10, 8'h03, 4'd2);
        drain_check("alu_mul");

        // Illegal command byte in IDLE
        exp_err++;
        send(8'h77);
        repeat (3) tick();
        chk("illegal_err", 32'(err_seen), 32'(exp_err));
        chk("illegal_no_rd", 32'(rd_seen), 32'(exp_rd));
        drain_check("illegal");

        // Byte dropped while the ALU is busy
        alu_lat = 6;
        push_result(alu_f(ref_rf[0], ref_rf[1], 4'd0));
        send_ng(8'hDD);
        send_ng(8'h00);
        exp_err++;
        send_ng(8'h55);
        wait_fifo();
        repeat (2) tick();
        chk("busy_drop_err", 32'(err_seen), 32'(exp_err));
        drain_check("busy_drop");
        alu_lat = 2;

`ifdef CMD_TIMEOUT_EN
        send_ng(8'hAA);
        send_ng(8'h02);
        repeat (TMO - 1) tick();
        chk("timeout_not_early", 32'(err_seen), 32'(exp_err));
        exp_err++;
        repeat (3) tick();
        chk("timeout_err", 32'(err_seen), 32'(exp_err));
        drain_check("timeout");
        do_nop(4'd5);
        drain_check("after_timeout");
`else
        send(8'hAA);
        send(8'h02);
        repeat (40) tick();
        chk("partial_no_err", 32'(err_seen), 32'(exp_err));
        chk("partial_no_wr", 32'(obs_wr.size()), 32'h0);
        exp_wr.push_back({4'd2, 8'h66});
        ref_rf[2] = 8'h66;
        send(8'h66);
        repeat (3) tick();
        drain_check("partial_resume");
`endif

        // Randomised frames with random back-pressure
        bp_mode = 1;
        for (int i = 0; i < 40; i++) begin
            kind    = $urandom_range(0, 4);
            alu_lat = $urandom_range(1, 5);
            case (kind)
                0: do_write(4'($urandom), 8'($urandom));
                1: do_read(4'($urandom));
                2: do_alu(8'($urandom), 8'($urandom), 4'($urandom_range(0, 7)));
                3: do_nop(4'($urandom_range(0, 7)));
                default: begin
                    do b = 8'($urandom);
                    while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
                    exp_err++;
                    send(b);
                end
            endcase
            repeat (3) tick();
            drain_check("rand");
        end
        bp_mode = 0;
        repeat (2) tick();
        chk("rand_rd_count", 32'(rd_seen), 32'(exp_rd));
        chk("rand_err_count", 32'(err_seen), 32'(exp_err));

        // Reset in the middle of a result push
        alu_lat = 2;
        exp_wr.push_back({4'd0, 8'h21});
        exp_wr.push_back({4'd1, 8'h04});
        ref_rf[0] = 8'h21;
        ref_rf[1] = 8'h04;
        send(8'hCC); send(8'h21); send(8'h04); send(8'h00);
        k = 0;
        while (bus.WR_INC !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        chk("reset_push_reached", 32'(bus.WR_INC), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_abort_outputs", 32'({bus.WR_INC, bus.Enable, bus.Gate_EN, bus.Wr_En, bus.Rd_En}), 32'h0);
        chk("reset_abort_clk_div", 32'(bus.clk_div_en), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        chk("reset_release_clk_div", 32'(bus.clk_div_en), 32'h1);
        repeat (5) tick();
        drain_check("reset_abort");
        do_read(4'd1);
        drain_check("after_reset");

        chk("no_push_while_full", 32'(full_viol), 32'h0);
        chk("gate_matches_enable", 32'(gate_viol), 32'h0);
        chk("final_err_count", 32'(err_seen), 32'(exp_err));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
